// File: rtl/rsv_station_pkg.sv
// Shared types for the reservation station: op fields, entry layout and helpers.
// RSV_CAPACITY sets the entry count; RSV_WAKEUP_EN adds per-source readiness bits.
`ifndef RSV_CAPACITY
`define RSV_CAPACITY 8
`endif

package rsv_station_pkg;

   localparam int CAP    = `RSV_CAPACITY;
   localparam int ID_W   = $clog2(CAP);
   localparam int OCC_W  = $clog2(CAP) + 1;

   typedef logic [ID_W-1:0] RsvID_t;
   typedef logic [5:0]      VRegIdx_t;
   typedef logic [31:0]     Word_t;

   typedef enum logic [3:0] {
      FC_ADD, FC_SUB, FC_AND, FC_OR, FC_XOR, FC_SLL, FC_LD, FC_ST
   } FuncCode_t;

   typedef enum logic [1:0] {
      FU_ALU, FU_MUL, FU_MEM, FU_BR
   } FuncUnitType_t;

   typedef struct packed {
      FuncCode_t     op;
      FuncUnitType_t fut;
      VRegIdx_t      ra;
      VRegIdx_t      rb;
      VRegIdx_t      rc;
      logic          rat;
      logic          rbt;
      logic          rct;
      Word_t         imm;
      VRegIdx_t      rd;
      logic          rdt;
      logic          rdValid;
`ifdef RSV_WAKEUP_EN
      logic          rdyA;
      logic          rdyB;
      logic          rdyC;
`endif
   } RsvEntry_t;

   function automatic logic [OCC_W-1:0] popcount(input logic [CAP-1:0] v);
      logic [OCC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < CAP; i++) begin
         cnt = cnt + OCC_W'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rsv_station_free_finder.sv
// Priority encoder over the free-entry vector: lowest free index plus an any-free flag.
module rsv_free_finder
   import rsv_station_pkg::*;
(
   input  logic [CAP-1:0] i_free,
   output RsvID_t         o_idx,
   output logic           o_any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = CAP - 1; i >= 0; i--) begin
         if (i_free[i]) begin
            o_idx = RsvID_t'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rsv_station.sv
// Reservation station: holds decoded ops until the dispatcher acks them.
// Build options: RSV_CAPACITY (entry count), RSV_WAKEUP_EN (operand readiness tracking).
module rsv_station
   import rsv_station_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          allocValid,
   output logic          allocReady,
   input  FuncCode_t     allocOp,
   input  FuncUnitType_t allocFut,
   input  VRegIdx_t      allocRa,
   input  VRegIdx_t      allocRb,
   input  VRegIdx_t      allocRc,
   input  logic          allocRat,
   input  logic          allocRbt,
   input  logic          allocRct,
   input  logic          allocRaUse,
   input  logic          allocRbUse,
   input  logic          allocRcUse,
   input  Word_t         allocImm,
   input  VRegIdx_t      allocRd,
   input  logic          allocRdt,
   input  logic          allocRdValid,
   output logic [CAP-1:0] opValid,
   output FuncCode_t     opIn         [CAP],
   output FuncUnitType_t funcUnitType [CAP],
   output VRegIdx_t      ra           [CAP],
   output VRegIdx_t      rb           [CAP],
   output VRegIdx_t      rc           [CAP],
   output logic          rat          [CAP],
   output logic          rbt          [CAP],
   output logic          rct          [CAP],
   output Word_t         imm          [CAP],
   output VRegIdx_t      rd           [CAP],
   output logic          rdt          [CAP],
   output logic          rdValid      [CAP],
   input  logic [CAP-1:0] dispatchAck,
   output logic [OCC_W-1:0] occupancy,
   input  logic          wbValid,
   input  VRegIdx_t      wbReg,
   input  logic          wbType
);

   logic [CAP-1:0] r_valid;
   RsvEntry_t      r_entry [CAP];

   RsvID_t         w_idx;
   logic           w_any_free;
   logic           w_fire;
   logic [CAP-1:0] w_fire_vec;
   RsvEntry_t      w_new;

   rsv_free_finder u_free_finder (
      .i_free (~r_valid),
      .o_idx  (w_idx),
      .o_any  (w_any_free)
   );

   assign allocReady = w_any_free;
   assign w_fire     = allocValid & w_any_free;
   assign w_fire_vec = w_fire ? (CAP'(1) << w_idx) : '0;
   assign occupancy  = popcount(r_valid);

`ifdef RSV_WAKEUP_EN
   function automatic logic wb_hit(input VRegIdx_t r, input logic t);
      return wbValid && (wbReg == r) && (wbType == t);
   endfunction
`endif

   always_comb begin
      w_new.op      = allocOp;
      w_new.fut     = allocFut;
      w_new.ra      = allocRa;
      w_new.rb      = allocRb;
      w_new.rc      = allocRc;
      w_new.rat     = allocRat;
      w_new.rbt     = allocRbt;
      w_new.rct     = allocRct;
      w_new.imm     = allocImm;
      w_new.rd      = allocRd;
      w_new.rdt     = allocRdt;
      w_new.rdValid = allocRdValid;
`ifdef RSV_WAKEUP_EN
      // A writeback in the allocating cycle would otherwise be missed by the entry.
      w_new.rdyA    = !allocRaUse || wb_hit(allocRa, allocRat);
      w_new.rdyB    = !allocRbUse || wb_hit(allocRb, allocRbt);
      w_new.rdyC    = !allocRcUse || wb_hit(allocRc, allocRct);
`endif
   end

   // Valid bits: ack clears, alloc sets; an ack on a free slot never masks a new alloc.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= '0;
      end else begin
         r_valid <= (r_valid & ~(dispatchAck & r_valid)) | w_fire_vec;
         assert ((dispatchAck & ~r_valid) == '0);
         assert ($onehot0(dispatchAck));
      end
   end

   // Payload is don't-care while invalid, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CAP; i++) begin
         if (w_fire_vec[i]) begin
            r_entry[i] <= w_new;
         end
`ifdef RSV_WAKEUP_EN
         else begin
            if (wb_hit(r_entry[i].ra, r_entry[i].rat)) r_entry[i].rdyA <= 1'b1;
            if (wb_hit(r_entry[i].rb, r_entry[i].rbt)) r_entry[i].rdyB <= 1'b1;
            if (wb_hit(r_entry[i].rc, r_entry[i].rct)) r_entry[i].rdyC <= 1'b1;
         end
`endif
      end
   end

   for (genvar gi = 0; gi < CAP; gi++) begin : g_out
`ifdef RSV_WAKEUP_EN
      assign opValid[gi] = r_valid[gi] & r_entry[gi].rdyA & r_entry[gi].rdyB & r_entry[gi].rdyC;
`else
      assign opValid[gi] = r_valid[gi];
`endif
      assign opIn[gi]         = r_entry[gi].op;
      assign funcUnitType[gi] = r_entry[gi].fut;
      assign ra[gi]           = r_entry[gi].ra;
      assign rb[gi]           = r_entry[gi].rb;
      assign rc[gi]           = r_entry[gi].rc;
      assign rat[gi]          = r_entry[gi].rat;
      assign rbt[gi]          = r_entry[gi].rbt;
      assign rct[gi]          = r_entry[gi].rct;
      assign imm[gi]          = r_entry[gi].imm;
      assign rd[gi]           = r_entry[gi].rd;
      assign rdt[gi]          = r_entry[gi].rdt;
      assign rdValid[gi]      = r_entry[gi].rdValid;
   end

`ifndef RSV_WAKEUP_EN
   logic w_unused;
   assign w_unused = ^{allocRaUse, allocRbUse, allocRcUse, wbValid, wbReg, wbType};
`endif

endmodule

// File: tb/tb_rsv_station.sv
// Directed bench for rsv_station: alloc/ack/flush sequencing and optional wakeup.
`timescale 1ns/1ps
module tb_rsv_station;
   import rsv_station_pkg::*;

   logic          clk = 1'b0;
   logic          rst, flush, allocValid, allocReady;
   FuncCode_t     allocOp;
   FuncUnitType_t allocFut;
   VRegIdx_t      allocRa, allocRb, allocRc, allocRd;
   logic          allocRat, allocRbt, allocRct;
   logic          allocRaUse, allocRbUse, allocRcUse;
   Word_t         allocImm;
   logic          allocRdt, allocRdValid;
   logic [CAP-1:0] opValid, dispatchAck;
   FuncCode_t     opIn [CAP];
   FuncUnitType_t funcUnitType [CAP];
   VRegIdx_t      ra [CAP], rb [CAP], rc [CAP], rd [CAP];
   logic          rat [CAP], rbt [CAP], rct [CAP], rdt [CAP], rdValid [CAP];
   Word_t         imm [CAP];
   logic [OCC_W-1:0] occupancy;
   logic          wbValid, wbType;
   VRegIdx_t      wbReg;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rsv_station dut (
      .clk(clk), .rst(rst), .flush(flush),
      .allocValid(allocValid), .allocReady(allocReady),
      .allocOp(allocOp), .allocFut(allocFut),
      .allocRa(allocRa), .allocRb(allocRb), .allocRc(allocRc),
      .allocRat(allocRat), .allocRbt(allocRbt), .allocRct(allocRct),
      .allocRaUse(allocRaUse), .allocRbUse(allocRbUse), .allocRcUse(allocRcUse),
      .allocImm(allocImm), .allocRd(allocRd), .allocRdt(allocRdt), .allocRdValid(allocRdValid),
      .opValid(opValid), .opIn(opIn), .funcUnitType(funcUnitType),
      .ra(ra), .rb(rb), .rc(rc), .rat(rat), .rbt(rbt), .rct(rct),
      .imm(imm), .rd(rd), .rdt(rdt), .rdValid(rdValid),
      .dispatchAck(dispatchAck), .occupancy(occupancy),
      .wbValid(wbValid), .wbReg(wbReg), .wbType(wbType)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alloc(input logic v, input FuncCode_t op, input Word_t im);
      allocValid = v;
      allocOp    = op;
      allocImm   = im;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; allocValid = 1'b0; allocOp = FC_ADD; allocFut = FU_ALU;
      allocRa = '0; allocRb = '0; allocRc = '0; allocRd = '0;
      allocRat = 1'b0; allocRbt = 1'b0; allocRct = 1'b0;
      allocRaUse = 1'b0; allocRbUse = 1'b0; allocRcUse = 1'b0;
      allocImm = '0; allocRdt = 1'b0; allocRdValid = 1'b0;
      dispatchAck = '0; wbValid = 1'b0; wbReg = '0; wbType = 1'b0;

      // 1: reset then a single ADD alloc
      tick(); tick();
      rst = 1'b0;
      check("rst_opvalid", 32'(opValid), 32'h0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_ready", 32'(allocReady), 32'd1);
      set_alloc(1'b1, FC_ADD, 32'h1234); allocFut = FU_MUL; allocRd = 6'd9; allocRdValid = 1'b1;
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0);
      check("a1_opvalid", 32'(opValid), 32'h01);
      check("a1_op", 32'(opIn[0]), 32'(FC_ADD));
      check("a1_fut", 32'(funcUnitType[0]), 32'(FU_MUL));
      check("a1_rd", 32'(rd[0]), 32'd9);
      check("a1_imm", imm[0], 32'h1234);
      check("a1_occ", 32'(occupancy), 32'd1);

      // 2: fill, overflow attempt, ack entry 4, refill lands in 4
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_alloc(1'b1, (i % 2 == 1) ? FC_SUB : FC_ADD, 32'h100 + 32'(i));
         tick();
      end
      check("full_occ", 32'(occupancy), 32'd8);
      check("full_ready", 32'(allocReady), 32'd0);
      check("full_op3", 32'(opIn[3]), 32'(FC_SUB));
      set_alloc(1'b1, FC_XOR, 32'hDEAD);
      tick();
      check("ovf_occ", 32'(occupancy), 32'd8);
      check("ovf_imm5", imm[5], 32'h105);
      dispatchAck = 8'h10;
      tick();
      dispatchAck = '0;
      check("ack4_opvalid", 32'(opValid), 32'hEF);
      check("ack4_ready", 32'(allocReady), 32'd1);
      check("ack4_occ", 32'(occupancy), 32'd7);
      set_alloc(1'b1, FC_LD, 32'h444);
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0);
      check("refill_opvalid", 32'(opValid), 32'hFF);
      check("refill_imm4", imm[4], 32'h444);
      check("refill_op4", 32'(opIn[4]), 32'(FC_LD));

      // 3: full with alloc and ack on entry 0 in the same cycle
      set_alloc(1'b1, FC_ST, 32'h333); dispatchAck = 8'h01;
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0); dispatchAck = '0;
      check("fullack_occ", 32'(occupancy), 32'd7);
      check("fullack_opvalid", 32'(opValid), 32'hFE);
      check("fullack_ready", 32'(allocReady), 32'd1);
      check("fullack_imm0", imm[0], 32'h100);

      // 4: three entries, alloc plus ack on entry 1
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_alloc(1'b1, FC_AND, 32'h10 + 32'(i));
         tick();
      end
      set_alloc(1'b1, FC_OR, 32'h13); dispatchAck = 8'h02;
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0); dispatchAck = '0;
      check("mix_occ", 32'(occupancy), 32'd3);
      check("mix_opvalid", 32'(opValid), 32'h0D);
      check("mix_imm3", imm[3], 32'h13);
      check("mix_op3", 32'(opIn[3]), 32'(FC_OR));

      // 5: flush wins over alloc and ack
      flush = 1'b1; set_alloc(1'b1, FC_SLL, 32'h99); dispatchAck = 8'h01;
      tick();
      flush = 1'b0; set_alloc(1'b0, FC_ADD, 32'h0); dispatchAck = '0;
      check("flush_opvalid", 32'(opValid), 32'h0);
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_ready", 32'(allocReady), 32'd1);
      set_alloc(1'b1, FC_SUB, 32'h55);
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0);
      check("postflush_opvalid", 32'(opValid), 32'h01);
      check("postflush_imm0", imm[0], 32'h55);

      // 6: operand wakeup (or its absence)
      rst = 1'b1; tick(); rst = 1'b0;
      allocRa = 6'd5; allocRat = 1'b0; allocRaUse = 1'b1;
      set_alloc(1'b1, FC_ADD, 32'h66);
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0);
`ifdef RSV_WAKEUP_EN
      check("wk_notready", 32'(opValid), 32'h0);
      check("wk_occ", 32'(occupancy), 32'd1);
      wbValid = 1'b1; wbReg = 6'd5; wbType = 1'b1;
      tick();
      check("wk_typemiss", 32'(opValid), 32'h0);
      wbType = 1'b0;
      tick();
      wbValid = 1'b0;
      check("wk_ready", 32'(opValid), 32'h01);
      allocRa = 6'd7;
      wbValid = 1'b1; wbReg = 6'd7; wbType = 1'b0;
      set_alloc(1'b1, FC_SUB, 32'h77);
      tick();
      set_alloc(1'b0, FC_ADD, 32'h0); wbValid = 1'b0;
      check("wk_bypass", 32'(opValid), 32'h03);
`else
      check("nowk_opvalid", 32'(opValid), 32'h01);
      check("nowk_occ", 32'(occupancy), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
